// File: rtl/video_pkg.sv
// Shared 640x480@60 raster constants and pixel/control types for the video path.
package video_pkg;

   localparam logic [9:0] H_VISIBLE = 10'd640;
   localparam logic [9:0] H_FP      = 10'd16;
   localparam logic [9:0] H_SYNC    = 10'd96;
   localparam logic [9:0] H_BP      = 10'd48;
   localparam logic [9:0] H_TOTAL   = 10'd800;
   localparam logic [9:0] V_VISIBLE = 10'd480;
   localparam logic [9:0] V_FP      = 10'd10;
   localparam logic [9:0] V_SYNC    = 10'd2;
   localparam logic [9:0] V_BP      = 10'd33;
   localparam logic [9:0] V_TOTAL   = 10'd525;

   localparam logic [9:0] HS_START = H_VISIBLE + H_FP;
   localparam logic [9:0] HS_END   = HS_START + H_SYNC - 10'd1;
   localparam logic [9:0] VS_START = V_VISIBLE + V_FP;
   localparam logic [9:0] VS_END   = VS_START + V_SYNC - 10'd1;

   typedef logic [11:0] rgb12_t;

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } vid_ctl_t;

   typedef struct packed {
      vid_ctl_t ctl;
      rgb12_t   rgb;
   } vid_px_t;

   localparam vid_ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};
   localparam vid_px_t  PX_IDLE  = '{ctl: CTL_IDLE, rgb: 12'h000};

   // Eight 80-pixel vertical bars across the visible width.
   function automatic rgb12_t bar_color(input logic [9:0] hc);
      logic [9:0] bar;
      bar = hc / 10'd80;
      case (bar)
         10'd0:   bar_color = 12'hFFF;
         10'd1:   bar_color = 12'hFF0;
         10'd2:   bar_color = 12'h0FF;
         10'd3:   bar_color = 12'h0F0;
         10'd4:   bar_color = 12'hF0F;
         10'd5:   bar_color = 12'hF00;
         10'd6:   bar_color = 12'h00F;
         default: bar_color = 12'h000;
      endcase
   endfunction

endpackage

// File: rtl/vid_delay_line.sv
// N-stage shift register for sync/enable plus pixel colour; the last stage blanks colour
// whenever its data-enable is low.
module vid_delay_line
   import video_pkg::*;
#(
   parameter int unsigned N = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   input  vid_ctl_t ctl_in,
   input  rgb12_t   rgb_in,
   output vid_ctl_t ctl_out,
   output rgb12_t   rgb_out
);

   vid_px_t src     [N];
   vid_px_t stage_d [N];
   vid_px_t stage_q [N];

   assign src[0] = '{ctl: ctl_in, rgb: rgb_in};
   for (genvar k = 1; k < N; k++) begin : g_src
      assign src[k] = stage_q[k-1];
   end

   always_comb begin
      for (int k = 0; k < int'(N); k++) begin
         stage_d[k] = src[k];
         if (k == int'(N) - 1 && !src[k].ctl.de) begin
            stage_d[k].rgb = 12'h000;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(N); k++) stage_q[k] <= PX_IDLE;
      end else begin
         for (int k = 0; k < int'(N); k++) stage_q[k] <= stage_d[k];
      end
   end

   assign ctl_out = stage_q[N-1].ctl;
   assign rgb_out = stage_q[N-1].rgb;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster generator with LATENCY-aligned sync/enable/colour outputs.
// Optional colour-bar substitution when VGA_TEST_PATTERN_EN is defined (adds test_mode).
module vga_timing_gen
   import video_pkg::*;
#(
   parameter int unsigned LATENCY = 1  // legal 1..4
) (
   input  logic        pixel_clk,
   input  logic        reset_n,
`ifdef VGA_TEST_PATTERN_EN
   input  logic        test_mode,
`endif
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   input  logic [3:0]  Red,
   input  logic [3:0]  Green,
   input  logic [3:0]  Blue,
   output logic        frame_start,
   output logic        line_start,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        vde_o,
   output logic [11:0] rgb_o
);

   logic [9:0] hc_q, hc_d;
   logic [9:0] vc_q, vc_d;
   vid_ctl_t   ctl0;
   vid_ctl_t   ctl_out;
   rgb12_t     rgb_in;

   always_comb begin
      hc_d = hc_q + 10'd1;
      vc_d = vc_q;
      if (hc_q == H_TOTAL - 10'd1) begin
         hc_d = 10'd0;
         vc_d = (vc_q == V_TOTAL - 10'd1) ? 10'd0 : vc_q + 10'd1;
      end
   end

   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         hc_q <= 10'd0;
         vc_q <= 10'd0;
      end else begin
         hc_q <= hc_d;
         vc_q <= vc_d;
      end
   end

   assign DrawX       = hc_q;
   assign DrawY       = vc_q;
   assign line_start  = (hc_q == 10'd0);
   assign frame_start = (hc_q == 10'd0) && (vc_q == 10'd0);

   assign ctl0.hs = !((hc_q >= HS_START) && (hc_q <= HS_END));
   assign ctl0.vs = !((vc_q >= VS_START) && (vc_q <= VS_END));
   assign ctl0.de = (hc_q < H_VISIBLE) && (vc_q < V_VISIBLE);

`ifdef VGA_TEST_PATTERN_EN
   assign rgb_in = test_mode ? bar_color(hc_q) : {Red, Green, Blue};
`else
   assign rgb_in = {Red, Green, Blue};
`endif

   vid_delay_line #(
      .N (LATENCY)
   ) u_delay (
      .clk     (pixel_clk),
      .rst_n   (reset_n),
      .ctl_in  (ctl0),
      .rgb_in  (rgb_in),
      .ctl_out (ctl_out),
      .rgb_out (rgb_o)
   );

   assign hsync_o = ctl_out.hs;
   assign vsync_o = ctl_out.vs;
   assign vde_o   = ctl_out.de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; jumps the vertical counter with force to stay short.
module tb_vga_timing_gen;

   localparam int LAT = 2;

   logic        pixel_clk = 1'b0;
   logic        reset_n   = 1'b0;
   logic        test_mode = 1'b0;
   logic [9:0]  DrawX, DrawY;
   logic [3:0]  Red, Green, Blue;
   logic        frame_start, line_start, hsync_o, vsync_o, vde_o;
   logic [11:0] rgb_o;

   int checks = 0;
   int errors = 0;

   always #5 pixel_clk = ~pixel_clk;

   // Colour source: F70 at exactly (100,50), 004 elsewhere.
   always_comb begin
      if (DrawX == 10'd100 && DrawY == 10'd50) {Red, Green, Blue} = 12'hF70;
      else                                     {Red, Green, Blue} = 12'h004;
   end

   vga_timing_gen #(
      .LATENCY (LAT)
   ) dut (
      .pixel_clk   (pixel_clk),
      .reset_n     (reset_n),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode   (test_mode),
`endif
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .Red         (Red),
      .Green       (Green),
      .Blue        (Blue),
      .frame_start (frame_start),
      .line_start  (line_start),
      .hsync_o     (hsync_o),
      .vsync_o     (vsync_o),
      .vde_o       (vde_o),
      .rgb_o       (rgb_o)
   );

   task automatic wait_xy(input logic [9:0] x, input logic [9:0] y, input int budget,
                          output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge pixel_clk);
         if (DrawX == x && DrawY == y) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Park the vertical counter on line v mid-line, holding the force across one edge.
   task automatic jump_line(input logic [9:0] v);
      for (int i = 0; i < 900; i++) begin
         @(negedge pixel_clk);
         if (DrawX == 10'd400) break;
      end
      force dut.vc_q = v;
      @(negedge pixel_clk);
      release dut.vc_q;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) @(negedge pixel_clk);
      checks++;
      if ({hsync_o, vsync_o, vde_o, rgb_o} !== {1'b1, 1'b1, 1'b0, 12'h000}) begin
         errors++;
         $display("FAIL reset_idle: got hs/vs/de/rgb=%b%b%b/%h want 110/000",
                  hsync_o, vsync_o, vde_o, rgb_o);
      end
      checks++;
      if (DrawX !== 10'd0 || DrawY !== 10'd0) begin
         errors++;
         $display("FAIL reset_counters: got %0d,%0d want 0,0", DrawX, DrawY);
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (frame_start !== 1'b1 || line_start !== 1'b1) begin
         errors++;
         $display("FAIL release_strobes: got fs=%b ls=%b want 1 1", frame_start, line_start);
      end
   endtask

   task automatic test_line_start;
      int n;
      logic [9:0] prev_x;
      n = 0;
      prev_x = DrawX;
      for (int i = 0; i < 2000; i++) begin
         @(negedge pixel_clk);
         n++;
         if (line_start) break;
         prev_x = DrawX;
      end
      checks++;
      if (n != 800) begin
         errors++;
         $display("FAIL line_period: got %0d want 800", n);
      end
      checks++;
      if (prev_x !== 10'd799 || DrawY !== 10'd1 || DrawX !== 10'd0) begin
         errors++;
         $display("FAIL line_wrap: got prev_x=%0d now %0d,%0d want 799 then 0,1",
                  prev_x, DrawX, DrawY);
      end
   endtask

   task automatic test_horizontal;
      bit ok;
      int k, low, de_run, rgb_bad;
      wait_xy(10'd656, 10'd1, 1000, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL h_reach: got timeout want (656,1)");
      end
      k = 0;
      while (hsync_o && k < 20) begin
         @(negedge pixel_clk);
         k++;
      end
      checks++;
      if (k != LAT) begin
         errors++;
         $display("FAIL hsync_fall_delay: got %0d want %0d", k, LAT);
      end
      low = 0;
      while (!hsync_o && low < 1000) begin
         low++;
         @(negedge pixel_clk);
      end
      checks++;
      if (low != 96) begin
         errors++;
         $display("FAIL hsync_width: got %0d want 96", low);
      end
      wait_xy(10'd0, 10'd2, 1000, ok);
      de_run = 0;
      rgb_bad = 0;
      for (int i = 0; i < 800; i++) begin
         @(negedge pixel_clk);
         if (vde_o) de_run++;
         if (vde_o && rgb_o !== 12'h004) rgb_bad++;
         if (!vde_o && rgb_o !== 12'h000) rgb_bad++;
      end
      checks++;
      if (de_run != 640) begin
         errors++;
         $display("FAIL vde_per_line: got %0d want 640", de_run);
      end
      checks++;
      if (rgb_bad != 0) begin
         errors++;
         $display("FAIL rgb_line_content: got %0d bad samples want 0", rgb_bad);
      end
   endtask

   task automatic test_vertical;
      bit ok;
      int k, low, de_cnt;
      jump_line(10'd489);
      wait_xy(10'd0, 10'd490, 1000, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL v_reach: got timeout want (0,490)");
      end
      k = 0;
      while (vsync_o && k < 20) begin
         @(negedge pixel_clk);
         k++;
      end
      checks++;
      if (k != LAT) begin
         errors++;
         $display("FAIL vsync_fall_delay: got %0d want %0d", k, LAT);
      end
      low = 0;
      while (!vsync_o && low < 4000) begin
         low++;
         @(negedge pixel_clk);
      end
      checks++;
      if (low != 1600) begin
         errors++;
         $display("FAIL vsync_width: got %0d want 1600", low);
      end
      jump_line(10'd478);
      wait_xy(10'd0, 10'd479, 1000, ok);
      de_cnt = 0;
      for (int i = 0; i < 1600; i++) begin
         @(negedge pixel_clk);
         if (vde_o) de_cnt++;
      end
      checks++;
      if (de_cnt != 640) begin
         errors++;
         $display("FAIL vde_last_lines: got %0d want 640", de_cnt);
      end
   endtask

   task automatic test_frame_wrap;
      bit ok;
      jump_line(10'd523);
      wait_xy(10'd799, 10'd524, 2000, ok);
      checks++;
      if (!ok || frame_start !== 1'b0) begin
         errors++;
         $display("FAIL frame_end: got ok=%b fs=%b want 1 0", ok, frame_start);
      end
      @(negedge pixel_clk);
      checks++;
      if (DrawX !== 10'd0 || DrawY !== 10'd0 || frame_start !== 1'b1) begin
         errors++;
         $display("FAIL frame_wrap: got %0d,%0d fs=%b want 0,0 fs=1", DrawX, DrawY, frame_start);
      end
      @(negedge pixel_clk);
      checks++;
      if (frame_start !== 1'b0 || DrawX !== 10'd1) begin
         errors++;
         $display("FAIL frame_start_pulse: got fs=%b x=%0d want 0 1", frame_start, DrawX);
      end
   endtask

   task automatic test_colour;
      bit ok;
      jump_line(10'd49);
      wait_xy(10'd100, 10'd50, 1000, ok);
      repeat (LAT - 1) @(negedge pixel_clk);
      checks++;
      if (!ok || rgb_o !== 12'h004) begin
         errors++;
         $display("FAIL colour_before: got ok=%b rgb=%h want 004", ok, rgb_o);
      end
      @(negedge pixel_clk);
      checks++;
      if (rgb_o !== 12'hF70) begin
         errors++;
         $display("FAIL colour_hit: got %h want F70", rgb_o);
      end
      @(negedge pixel_clk);
      checks++;
      if (rgb_o !== 12'h004) begin
         errors++;
         $display("FAIL colour_after: got %h want 004", rgb_o);
      end
   endtask

   task automatic test_mid_reset;
      bit ok;
      jump_line(10'd199);
      wait_xy(10'd300, 10'd200, 1000, ok);
      checks++;
      if (!ok || vde_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: got ok=%b vde=%b want 1 1", ok, vde_o);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({hsync_o, vsync_o, vde_o, rgb_o} !== {1'b1, 1'b1, 1'b0, 12'h000}) begin
         errors++;
         $display("FAIL mid_async_idle: got hs/vs/de/rgb=%b%b%b/%h want 110/000",
                  hsync_o, vsync_o, vde_o, rgb_o);
      end
      @(negedge pixel_clk);
      reset_n = 1'b1;
      #1;
      checks++;
      if (DrawX !== 10'd0 || DrawY !== 10'd0 || frame_start !== 1'b1) begin
         errors++;
         $display("FAIL mid_restart: got %0d,%0d fs=%b want 0,0 fs=1", DrawX, DrawY, frame_start);
      end
      @(negedge pixel_clk);
      checks++;
      if (DrawX !== 10'd1 || DrawY !== 10'd0) begin
         errors++;
         $display("FAIL mid_advance: got %0d,%0d want 1,0", DrawX, DrawY);
      end
   endtask

`ifdef VGA_TEST_PATTERN_EN
   task automatic test_pattern;
      logic [9:0]  px  [4];
      logic [11:0] exp [4];
      bit ok;
      px[0] = 10'd0;   exp[0] = 12'hFFF;
      px[1] = 10'd80;  exp[1] = 12'hFF0;
      px[2] = 10'd320; exp[2] = 12'hF0F;
      px[3] = 10'd560; exp[3] = 12'h000;
      test_mode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_xy(px[i], 10'd3, 2000, ok);
         repeat (LAT) @(negedge pixel_clk);
         checks++;
         if (!ok || rgb_o !== exp[i]) begin
            errors++;
            $display("FAIL bar_%0d: got ok=%b rgb=%h want %h", px[i], ok, rgb_o, exp[i]);
         end
      end
      test_mode = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_line_start();
      test_horizontal();
`ifdef VGA_TEST_PATTERN_EN
      test_pattern();
`endif
      test_vertical();
      test_frame_wrap();
      test_colour();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
